// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter: three-way round-robin arbiter in front of a single BRAM port.
// Requester 0 = maze generator, 1 = player/collision, 2 = renderer.
// Optional build macro MAZE_ARB_CLEAR_EN adds a 256-cycle post-reset clear sweep
// that writes CLEAR_VALUE to every cell before any requester is served.
//
// Handshake: a requester raises req[i] with req_we/req_addr/req_wdata and holds
// them stable until gnt[i]; gnt is combinational and marks the very cycle the BRAM
// is accessed. A req still high after gnt is a new request. A read granted in
// cycle N returns rvalid[i] with rdata in cycle N+1; writes never raise rvalid.
module maze_port_arbiter #(
    parameter logic [8:0] CLEAR_VALUE = 9'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [2:0]  req_we,
    input  logic [23:0] req_addr,
    input  logic [26:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [8:0]  rdata,
    output logic        bram_en,
    output logic        bram_we,
    output logic [7:0]  bram_addr,
    output logic [8:0]  bram_din,
    input  logic [8:0]  bram_dout,
    output logic        busy
);

    logic [1:0] ptr;
    logic [1:0] ptr_nx;
    logic [1:0] sel_idx;
    logic [2:0] sel_oh;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [8:0] sel_din;
    logic       grant_any;

`ifdef MAZE_ARB_CLEAR_EN
    typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;
    state_t     state;
    state_t     state_nx;
    logic [7:0] clr_cnt;

    // State register and sweep address counter; counter only advances while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_cnt <= clr_cnt + 8'd1;
        end
    end

    // Next state: leave CLEAR once the last cell (255) has been written; SERVE is terminal.
    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_cnt == 8'hFF) state_nx = SERVE;
    end
`endif

    // Round-robin pick: first asserted request starting at ptr, wrapping mod 3.
    always_comb begin
        grant_any = |req;
        sel_idx   = 2'd0;
        unique case (ptr)
            2'd1:    sel_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    sel_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: sel_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Steer the picked requester's fields onto the BRAM side and compute the next pointer.
    always_comb begin
        sel_oh   = 3'b001;
        sel_we   = req_we[0];
        sel_addr = req_addr[7:0];
        sel_din  = req_wdata[8:0];
        ptr_nx   = 2'd1;
        case (sel_idx)
            2'd1: begin
                sel_oh   = 3'b010;
                sel_we   = req_we[1];
                sel_addr = req_addr[15:8];
                sel_din  = req_wdata[17:9];
                ptr_nx   = 2'd2;
            end
            2'd2: begin
                sel_oh   = 3'b100;
                sel_we   = req_we[2];
                sel_addr = req_addr[23:16];
                sel_din  = req_wdata[26:18];
                ptr_nx   = 2'd0;
            end
            default: ;
        endcase
    end

    // Output decode; everything that touches the BRAM is forced idle while rst_n is low.
    always_comb begin
        gnt       = 3'b000;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = 8'h00;
        bram_din  = CLEAR_VALUE;
        busy      = 1'b0;
        if (rst_n) begin
`ifdef MAZE_ARB_CLEAR_EN
            if (state == CLEAR) begin
                busy      = 1'b1;
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = clr_cnt;
            end else
`endif
            if (grant_any) begin
                gnt       = sel_oh;
                bram_en   = 1'b1;
                bram_we   = sel_we;
                bram_addr = sel_addr;
                bram_din  = sel_din;
            end
        end
    end

    // Pointer advances past each winner; read grants become next-cycle rvalid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 2'd0;
            rvalid <= 3'b000;
        end else begin
            rvalid <= gnt & ~req_we;
            if (|gnt) ptr <= ptr_nx;
        end
    end

    // BRAM output register already provides the one-cycle read latency.
    assign rdata = bram_dout;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with a behavioural single-port BRAM.
module tb_maze_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  req_we = 3'b000;
    logic [23:0] req_addr = '0;
    logic [26:0] req_wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [8:0]  rdata;
    logic        bram_en;
    logic        bram_we;
    logic [7:0]  bram_addr;
    logic [8:0]  bram_din;
    logic [8:0]  bram_dout = 9'h000;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] mem [0:255];
    logic       load_pat = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    maze_port_arbiter #(.CLEAR_VALUE(9'h000)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
    );

    // BRAM model: registered read, write-first not needed (single port)
    always @(posedge clk) begin
        if (load_pat) begin
            for (int i = 0; i < 256; i++) mem[i] <= 9'h100 | 9'(i);
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic we, input logic [7:0] a, input logic [8:0] d);
        req_we[i]          = we;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*9 +: 9] = d;
    endtask

    task automatic wait_sweep();
`ifdef MAZE_ARB_CLEAR_EN
        for (int c = 0; c < 300 && busy; c++) step();
        check_eq("sweep_done", {31'd0, busy}, 32'd0);
`endif
    endtask

    task automatic check_sweep_full();
        for (int c = 0; c < 256; c++) begin
            check_eq("sweep_busy", {31'd0, busy}, 32'd1);
            check_eq("sweep_gnt", {29'd0, gnt}, 32'd0);
            check_eq("sweep_en_we", {30'd0, bram_en, bram_we}, 32'd3);
            check_eq("sweep_addr", {24'd0, bram_addr}, c);
            check_eq("sweep_din", {23'd0, bram_din}, 32'h000);
            step();
        end
        check_eq("sweep_first_gnt", {29'd0, gnt}, 32'b001);
        check_eq("sweep_busy_off", {31'd0, busy}, 32'd0);
    endtask

    logic [2:0] rr_seq [0:5];
    logic [8:0] rr_dat [0:2];

    initial begin
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
        rr_dat[0] = 9'h011; rr_dat[1] = 9'h022; rr_dat[2] = 9'h033;

        // reset state with all requests pending
        req = 3'b111;
        load_pat = 1'b1;
        step();
        step();
        load_pat = 1'b0;
        check_eq("rst_gnt", {29'd0, gnt}, 32'd0);
        check_eq("rst_rvalid", {29'd0, rvalid}, 32'd0);
        check_eq("rst_en_we", {30'd0, bram_en, bram_we}, 32'd0);

`ifdef MAZE_ARB_CLEAR_EN
        // sweep interrupted at 0x80 restarts from 0
        rst_n = 1'b1;
        for (int c = 0; c < 128; c++) step();
        check_eq("mid_addr", {24'd0, bram_addr}, 32'h80);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt", {29'd0, gnt}, 32'd0);
        check_eq("mid_rst_en_we", {30'd0, bram_en, bram_we}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("restart_addr", {24'd0, bram_addr}, 32'h00);
        check_eq("restart_busy", {31'd0, busy}, 32'd1);
        check_sweep_full();
        req = 3'b000;
        // back to ptr=0 for the common section
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_sweep();
`else
        // first cycle after release is already SERVE
        set_port(1, 1'b0, 8'h05, 9'h000);
        req = 3'b010;
        rst_n = 1'b1;
        #1;
        check_eq("first_gnt", {29'd0, gnt}, 32'b010);
        check_eq("first_busy", {31'd0, busy}, 32'd0);
        check_eq("first_addr", {24'd0, bram_addr}, 32'h05);
        step();
        req = 3'b000;
        #1;
        check_eq("first_rvalid", {29'd0, rvalid}, 32'b010);
        check_eq("first_rdata", {23'd0, rdata}, 32'h105);
        check_eq("idle_en", {30'd0, bram_en, bram_we}, 32'd0);
        step();
        check_eq("first_rvalid_pulse", {29'd0, rvalid}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif

        // preload three cells through requester 0 (held req = new request each cycle)
        req = 3'b001;
        for (int k = 0; k < 3; k++) begin
            set_port(0, 1'b1, 8'(16 + 16 * k), rr_dat[k]);
            #1;
            check_eq("pre_gnt", {29'd0, gnt}, 32'b001);
            check_eq("pre_we", {31'd0, bram_we}, 32'd1);
            step();
            check_eq("pre_no_rvalid", {29'd0, rvalid}, 32'd0);
        end
        // single grant to 2 moves ptr from 1 back to 0
        req = 3'b100;
        set_port(2, 1'b1, 8'h40, 9'h044);
        #1;
        check_eq("wrap_gnt", {29'd0, gnt}, 32'b100);
        step();

        // round robin, all reads
        set_port(0, 1'b0, 8'h10, 9'h000);
        set_port(1, 1'b0, 8'h20, 9'h000);
        set_port(2, 1'b0, 8'h30, 9'h000);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq("rr_gnt", {29'd0, gnt}, {29'd0, rr_seq[k]});
            check_eq("rr_addr", {24'd0, bram_addr}, 32'h10 * ((k % 3) + 1));
            if (k > 0) begin
                check_eq("rr_rvalid", {29'd0, rvalid}, {29'd0, rr_seq[k-1]});
                check_eq("rr_rdata", {23'd0, rdata}, {23'd0, rr_dat[(k-1) % 3]});
            end
            step();
        end
        req = 3'b000;
        #1;
        check_eq("rr_rvalid_last", {29'd0, rvalid}, 32'b100);
        check_eq("rr_rdata_last", {23'd0, rdata}, 32'h033);
        step();

        // write then read same address
        req = 3'b001;
        set_port(0, 1'b1, 8'h3C, 9'h1A5);
        #1;
        check_eq("wr_gnt", {29'd0, gnt}, 32'b001);
        check_eq("wr_bus", {13'd0, bram_we, bram_addr, bram_din}, {13'd0, 1'b1, 8'h3C, 9'h1A5});
        step();
        req = 3'b010;
        set_port(1, 1'b0, 8'h3C, 9'h000);
        #1;
        check_eq("rd_gnt", {29'd0, gnt}, 32'b010);
        check_eq("rd_we", {31'd0, bram_we}, 32'd0);
        check_eq("wr_no_rvalid", {29'd0, rvalid}, 32'd0);
        step();
        req = 3'b000;
        #1;
        check_eq("rd_rvalid", {29'd0, rvalid}, 32'b010);
        check_eq("rd_rdata", {23'd0, rdata}, 32'h1A5);

        // ptr is 2; one grant to 0 makes ptr=1, then partial request 101
        set_port(0, 1'b0, 8'h10, 9'h000);
        req = 3'b001;
        #1;
        check_eq("part_setup_gnt", {29'd0, gnt}, 32'b001);
        step();
        req = 3'b101;
        #1;
        check_eq("part_gnt_a", {29'd0, gnt}, 32'b100);
        check_eq("part_rdata_a", {23'd0, rdata}, 32'h011);
        step();
        #1;
        check_eq("part_gnt_b", {29'd0, gnt}, 32'b001);
        check_eq("part_rvalid_b", {29'd0, rvalid}, 32'b100);
        check_eq("part_rdata_b", {23'd0, rdata}, 32'h033);
        step();
        req = 3'b000;
        #1;
        check_eq("idle_gnt", {29'd0, gnt}, 32'd0);
        check_eq("idle_en_we", {30'd0, bram_en, bram_we}, 32'd0);
        check_eq("part_rvalid_c", {29'd0, rvalid}, 32'b001);
        step();
        check_eq("idle_rvalid", {29'd0, rvalid}, 32'd0);

        // reset between read grant and its rvalid drops the pulse; ptr returns to 0
        req = 3'b010;
        set_port(1, 1'b0, 8'h20, 9'h000);
        #1;
        check_eq("drop_gnt", {29'd0, gnt}, 32'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("drop_rst_gnt", {29'd0, gnt}, 32'd0);
        check_eq("drop_rst_en", {30'd0, bram_en, bram_we}, 32'd0);
        step();
        check_eq("drop_rvalid", {29'd0, rvalid}, 32'd0);
        req = 3'b000;
        rst_n = 1'b1;
        wait_sweep();
        req = 3'b101;
        set_port(0, 1'b0, 8'h10, 9'h000);
        set_port(2, 1'b0, 8'h30, 9'h000);
        #1;
        check_eq("ptr_after_rst", {29'd0, gnt}, 32'b001);
        step();
        req = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
